// File: rtl/npu_feed_seq.sv
// npu_feed_seq: accepts a convolution command and sequences upstream beats into NPUCore, timing adder_rst and result_valid.
// Define NPU_FEED_BIAS_EN to inject the per-channel bias on the first beat of each command.
module npu_feed_seq #(
   parameter int NPU_IN_NUM   = 9,
   parameter int NPU_OUT_NUM  = 18,
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int BIAS_WIDTH   = 16,
   parameter int ADD_LAT      = 3,
   parameter int OUT_LAT      = 7,
   parameter int GRP_W        = 16
) (
   input  logic                                            clk,
   input  logic                                            rstn,
   input  logic                                            cmd_valid,
   output logic                                            cmd_ready,
   input  logic [GRP_W-1:0]                                cmd_groups,
   input  logic [3:0]                                      cmd_scale,
   input  logic [BIAS_WIDTH*NPU_OUT_NUM-1:0]               cmd_bias,
   input  logic [NPU_IN_NUM*DATA_WIDTH*NPU_OUT_NUM-1:0]    s_data,
   input  logic [NPU_IN_NUM*WEIGHT_WIDTH*NPU_OUT_NUM-1:0]  s_weight,
   input  logic                                            s_valid,
   output logic                                            s_ready,
   output logic [NPU_IN_NUM*DATA_WIDTH*NPU_OUT_NUM-1:0]    npu_data,
   output logic [NPU_IN_NUM*WEIGHT_WIDTH*NPU_OUT_NUM-1:0]  npu_weight,
   output logic [BIAS_WIDTH*NPU_OUT_NUM-1:0]               npu_bias,
   output logic                                            npu_data_valid,
   output logic                                            npu_weight_valid,
   output logic                                            npu_bias_valid,
   output logic [3:0]                                      npu_scale,
   output logic [NPU_OUT_NUM-1:0]                          adder_rst,
   output logic                                            result_valid,
   output logic                                            busy
);

   localparam int DW = NPU_IN_NUM*DATA_WIDTH*NPU_OUT_NUM;
   localparam int WW = NPU_IN_NUM*WEIGHT_WIDTH*NPU_OUT_NUM;
   localparam int BW = BIAS_WIDTH*NPU_OUT_NUM;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t            state_q, state_d;
   logic [GRP_W-1:0]  remain_q, remain_d;
   logic              first_q, first_d;
   logic [3:0]        scale_q, scale_d;
   logic [DW-1:0]     data_q, data_d;
   logic [WW-1:0]     weight_q, weight_d;
   logic              vld_q, vld_d;
   logic              first_tag_q, first_tag_d;
   logic              last_tag_q, last_tag_d;
   logic [ADD_LAT-1:0] add_sr_q;
   logic [OUT_LAT-1:0] out_sr_q;
   logic              cmd_acc, beat_acc;

   assign cmd_acc  = (state_q == IDLE) && cmd_valid;
   assign beat_acc = (state_q == STREAM) && s_valid;

   always_comb begin
      state_d     = state_q;
      remain_d    = remain_q;
      first_d     = first_q;
      scale_d     = scale_q;
      data_d      = '0;
      weight_d    = '0;
      vld_d       = 1'b0;
      first_tag_d = 1'b0;
      last_tag_d  = 1'b0;
      cmd_ready   = 1'b0;
      s_ready     = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_acc) begin
               remain_d = (cmd_groups == '0) ? GRP_W'(1) : cmd_groups;
               first_d  = 1'b1;
               scale_d  = cmd_scale;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            s_ready = 1'b1;
            // Bubbles leave the zero defaults in place so the NPU accumulates nothing.
            if (beat_acc) begin
               data_d      = s_data;
               weight_d    = s_weight;
               vld_d       = 1'b1;
               first_tag_d = first_q;
               last_tag_d  = (remain_q == GRP_W'(1));
               first_d     = 1'b0;
               remain_d    = remain_q - GRP_W'(1);
               if (remain_q == GRP_W'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         remain_q    <= '0;
         first_q     <= 1'b0;
         scale_q     <= '0;
         data_q      <= '0;
         weight_q    <= '0;
         vld_q       <= 1'b0;
         first_tag_q <= 1'b0;
         last_tag_q  <= 1'b0;
         add_sr_q    <= '0;
         out_sr_q    <= '0;
      end else begin
         state_q     <= state_d;
         remain_q    <= remain_d;
         first_q     <= first_d;
         scale_q     <= scale_d;
         data_q      <= data_d;
         weight_q    <= weight_d;
         vld_q       <= vld_d;
         first_tag_q <= first_tag_d;
         last_tag_q  <= last_tag_d;
         // Tags follow the beat out of the output register, then age independently of the FSM.
         add_sr_q    <= (add_sr_q << 1) | ADD_LAT'(first_tag_q);
         out_sr_q    <= (out_sr_q << 1) | OUT_LAT'(last_tag_q);
      end
   end

`ifdef NPU_FEED_BIAS_EN
   logic [BW-1:0] bias_q, bias_d, bias_out_q, bias_out_d;
   logic          bias_vld_q, bias_vld_d;

   always_comb begin
      bias_d     = bias_q;
      bias_out_d = '0;
      bias_vld_d = 1'b0;
      if (cmd_acc) bias_d = cmd_bias;
      // NPUCore adds its bias input on every beat, so only the first beat may carry it.
      if (beat_acc && first_q) begin
         bias_out_d = bias_q;
         bias_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bias_q     <= '0;
         bias_out_q <= '0;
         bias_vld_q <= 1'b0;
      end else begin
         bias_q     <= bias_d;
         bias_out_q <= bias_out_d;
         bias_vld_q <= bias_vld_d;
      end
   end

   assign npu_bias       = bias_out_q;
   assign npu_bias_valid = bias_vld_q;
`else
   logic unused_bias;
   assign unused_bias    = ^cmd_bias;
   assign npu_bias       = '0;
   assign npu_bias_valid = 1'b0;
`endif

   assign npu_data         = data_q;
   assign npu_weight       = weight_q;
   assign npu_data_valid   = vld_q;
   assign npu_weight_valid = vld_q;
   assign npu_scale        = scale_q;
   assign adder_rst        = {NPU_OUT_NUM{add_sr_q[ADD_LAT-1]}};
   assign result_valid     = out_sr_q[OUT_LAT-1];
   assign busy             = (state_q != IDLE) || first_tag_q || last_tag_q ||
                             (|add_sr_q) || (|out_sr_q);

endmodule
